// File: rtl/activation_stack.sv
// LIFO of WIDTH-bit activation vectors for the cpu stack port: the top entry is held in a
// register and deeper entries sit in a synchronous-read BRAM, so a pop with entries left costs one refill cycle.
//   state  | meaning
//   READY  | handshakes accepted; top_reg holds entry count-1 when count > 0
//   REFILL | BRAM read in flight; top_reg reloads next edge, both handshakes held off
module activation_stack #(
    parameter int WIDTH = 1024,
    parameter int DEPTH = 16
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic [WIDTH-1:0]           push_data_in,
    input  logic                       push_valid_in,
    output logic                       push_ready_out,
    output logic [WIDTH-1:0]           top_out,
    output logic                       top_valid_out,
    input  logic                       pop_ready_in,
    output logic [$clog2(DEPTH+1)-1:0] depth_out,
    output logic                       empty_out,
    output logic                       full_out
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 2) ? $clog2(DEPTH - 1) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [CW-1:0] TWO_C   = CW'(2);

    typedef enum logic {READY, REFILL} state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     count, count_nxt;
    logic [WIDTH-1:0]  top_reg;
    logic [WIDTH-1:0]  rd_data;
    logic [WIDTH-1:0]  mem [DEPTH-1];
    logic              push_ready_q, top_valid_q;
    logic              push_fire, pop_fire;
    logic              mem_we, mem_re;
    logic [AW-1:0]     wr_addr, rd_addr;

    assign push_fire = push_valid_in && push_ready_q;
    assign pop_fire  = pop_ready_in && top_valid_q;

    // Simultaneous push and pop replaces the top in place and never touches the BRAM.
    assign mem_we  = !rst_in && push_fire && !pop_fire && (count != '0);
    assign mem_re  = !rst_in && pop_fire && !push_fire && (count > ONE_C);
    assign wr_addr = AW'(count - ONE_C);
    assign rd_addr = AW'(count - TWO_C);

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        case (state)
            READY: begin
                if (push_fire && !pop_fire) begin
                    count_nxt = count + ONE_C;
                end else if (pop_fire && !push_fire) begin
                    count_nxt = count - ONE_C;
                    if (count > ONE_C) state_nxt = REFILL;
                end
            end
            REFILL: state_nxt = READY;
            default: state_nxt = READY;
        endcase
    end

    // Handshake flags are registered from next-state values so no input reaches an output.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state        <= READY;
            count        <= '0;
            top_reg      <= '0;
            push_ready_q <= 1'b1;
            top_valid_q  <= 1'b0;
        end else begin
            state        <= state_nxt;
            count        <= count_nxt;
            push_ready_q <= (state_nxt == READY) && (count_nxt < DEPTH_C);
            top_valid_q  <= (state_nxt == READY) && (count_nxt != '0);
            if (state == REFILL)
                top_reg <= rd_data;
            else if (push_fire)
                top_reg <= push_data_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (mem_we) mem[wr_addr] <= top_reg;
        if (mem_re) rd_data <= mem[rd_addr];
    end

    assign push_ready_out = push_ready_q;
    assign top_valid_out  = top_valid_q;
    assign top_out        = top_reg;
    assign depth_out      = count;
    assign empty_out      = (count == '0);
    assign full_out       = (count == DEPTH_C);

endmodule

// File: tb/tb_activation_stack.sv
// Bench for activation_stack (DEPTH=4, WIDTH=8): directed vector table, a LIFO drain
// sequence, then random traffic checked against a queue-based model.
module tb_activation_stack;

    localparam int W = 8;
    localparam int D = 4;

    logic         clk_in = 1'b0;
    logic         rst_in = 1'b1;
    logic [W-1:0] push_data_in = '0;
    logic         push_valid_in = 1'b0;
    logic         push_ready_out;
    logic [W-1:0] top_out;
    logic         top_valid_out;
    logic         pop_ready_in = 1'b0;
    logic [2:0]   depth_out;
    logic         empty_out;
    logic         full_out;

    int checks = 0;
    int errors = 0;

    activation_stack #(.WIDTH(W), .DEPTH(D)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .push_data_in(push_data_in), .push_valid_in(push_valid_in),
        .push_ready_out(push_ready_out),
        .top_out(top_out), .top_valid_out(top_valid_out),
        .pop_ready_in(pop_ready_in),
        .depth_out(depth_out), .empty_out(empty_out), .full_out(full_out)
    );

    always #5 clk_in = ~clk_in;

    // Reference: stack contents as a queue (back = top) plus a one-cycle bubble after a refilling pop.
    logic [W-1:0] mq[$];
    bit           bubble = 0;

    task automatic model_step(input logic r, input logic pv, input logic [W-1:0] d, input logic pr);
        bit can_push, can_pop, pf, qf;
        can_push = !bubble && (mq.size() < D);
        can_pop  = !bubble && (mq.size() > 0);
        pf = pv && can_push;
        qf = pr && can_pop;
        if (r) begin
            mq.delete();
            bubble = 0;
        end else if (bubble) begin
            bubble = 0;
        end else if (pf && qf) begin
            mq[mq.size()-1] = d;
        end else if (pf) begin
            mq.push_back(d);
        end else if (qf) begin
            void'(mq.pop_back());
            if (mq.size() > 0) bubble = 1;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input logic r, input logic pv, input logic [W-1:0] d, input logic pr);
        rst_in        = r;
        push_valid_in = pv;
        push_data_in  = d;
        pop_ready_in  = pr;
        @(posedge clk_in);
        model_step(r, pv, d, pr);
        #1;
    endtask

    task automatic check_model(input string tag);
        int n;
        bit tv;
        n  = mq.size();
        tv = !bubble && n > 0;
        chk({tag, "_depth"}, int'(depth_out), n);
        chk({tag, "_top_valid"}, int'(top_valid_out), int'(tv));
        chk({tag, "_push_ready"}, int'(push_ready_out), int'(!bubble && n < D));
        chk({tag, "_empty"}, int'(empty_out), int'(n == 0));
        chk({tag, "_full"}, int'(full_out), int'(n == D));
        if (tv) chk({tag, "_top"}, int'(top_out), int'(mq[n-1]));
    endtask

    typedef struct {
        logic         rst;
        logic         pv;
        logic [W-1:0] data;
        logic         pr;
        int           exp_depth;
        logic         exp_tv;
        logic         exp_prdy;
        bit           chk_top;
        logic [W-1:0] exp_top;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, input logic pv, input logic [W-1:0] d, input logic pr,
                       input int ed, input logic etv, input logic eprdy, input bit ct,
                       input logic [W-1:0] et);
        vec_t v;
        v.rst = r; v.pv = pv; v.data = d; v.pr = pr;
        v.exp_depth = ed; v.exp_tv = etv; v.exp_prdy = eprdy; v.chk_top = ct; v.exp_top = et;
        vq.push_back(v);
    endtask

    initial begin
        logic [W-1:0] pushed[$];
        logic [W-1:0] popped[$];
        logic [W-1:0] v8;

        // rst pv data pr | depth tv prdy chk_top top
        add(1, 0, 8'h00, 0, 0, 0, 1, 1, 8'h00);
        add(0, 1, 8'hA1, 0, 1, 1, 1, 1, 8'hA1);
        add(0, 1, 8'hA2, 0, 2, 1, 1, 1, 8'hA2);
        add(0, 1, 8'hA3, 0, 3, 1, 1, 1, 8'hA3);
        add(0, 0, 8'h00, 1, 2, 0, 0, 0, 8'h00);
        add(0, 0, 8'h00, 0, 2, 1, 1, 1, 8'hA2);
        add(0, 1, 8'hA3, 0, 3, 1, 1, 1, 8'hA3);
        add(0, 1, 8'hA4, 0, 4, 1, 0, 1, 8'hA4);
        add(0, 1, 8'hFF, 0, 4, 1, 0, 1, 8'hA4);
        add(0, 0, 8'h00, 1, 3, 0, 0, 0, 8'h00);
        add(0, 0, 8'h00, 0, 3, 1, 1, 1, 8'hA3);
        add(0, 0, 8'h00, 1, 2, 0, 0, 0, 8'h00);
        add(0, 0, 8'h00, 0, 2, 1, 1, 1, 8'hA2);
        add(0, 1, 8'h5D, 1, 2, 1, 1, 1, 8'h5D);
        add(0, 0, 8'h00, 1, 1, 0, 0, 0, 8'h00);
        add(0, 0, 8'h00, 0, 1, 1, 1, 1, 8'hA1);
        add(0, 0, 8'h00, 1, 0, 0, 1, 0, 8'h00);
        add(0, 0, 8'h00, 1, 0, 0, 1, 0, 8'h00);
        add(0, 0, 8'h00, 1, 0, 0, 1, 0, 8'h00);
        add(0, 0, 8'h00, 1, 0, 0, 1, 0, 8'h00);
        add(0, 1, 8'h11, 0, 1, 1, 1, 1, 8'h11);
        add(0, 1, 8'h22, 0, 2, 1, 1, 1, 8'h22);
        add(0, 1, 8'h33, 0, 3, 1, 1, 1, 8'h33);
        add(0, 0, 8'h00, 1, 2, 0, 0, 0, 8'h00);
        add(1, 1, 8'h77, 1, 0, 0, 1, 1, 8'h00);

        foreach (vq[i]) begin
            cycle(vq[i].rst, vq[i].pv, vq[i].data, vq[i].pr);
            chk($sformatf("vec%0d_depth", i), int'(depth_out), vq[i].exp_depth);
            chk($sformatf("vec%0d_top_valid", i), int'(top_valid_out), int'(vq[i].exp_tv));
            chk($sformatf("vec%0d_push_ready", i), int'(push_ready_out), int'(vq[i].exp_prdy));
            chk($sformatf("vec%0d_empty", i), int'(empty_out), int'(vq[i].exp_depth == 0));
            chk($sformatf("vec%0d_full", i), int'(full_out), int'(vq[i].exp_depth == D));
            if (vq[i].chk_top)
                chk($sformatf("vec%0d_top", i), int'(top_out), int'(vq[i].exp_top));
        end

        // Fill to full back-to-back, then hold pop_ready and collect tops until empty.
        cycle(1, 0, 8'h00, 0);
        for (int i = 0; i < D; i++) begin
            v8 = 8'($urandom);
            pushed.push_back(v8);
            cycle(0, 1, v8, 0);
        end
        check_model("fill");
        for (int i = 0; i < 20 && popped.size() < D; i++) begin
            if (top_valid_out) popped.push_back(top_out);
            cycle(0, 0, 8'h00, 1);
        end
        chk("drain_count", popped.size(), D);
        for (int i = 0; i < D && i < popped.size(); i++)
            chk($sformatf("drain_order%0d", i), int'(popped[i]), int'(pushed[D-1-i]));
        cycle(0, 0, 8'h00, 0);
        check_model("drained");

        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 79) == 0), ($urandom_range(0, 9) < 6),
                  8'($urandom), ($urandom_range(0, 9) < 5));
            check_model("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
